mux_share_arbiter: RTL and testbench

//   Shares one registered-select output mux between N requesters with round-robin arbitration.

---
 rtl/mux_share_arbiter_pkg.sv | 36 +++
 rtl/mux_share_arbiter_if.sv | 39 +++
 rtl/mux_share_arbiter_rr_picker.sv | 45 ++++
 rtl/mux_share_arbiter.sv | 95 +++++++++
 tb/tb_mux_share_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mux_share_arbiter_pkg.sv
// Shared types and helpers for mux_share_arbiter.
// Optional burst locking is enabled by defining MUX_SHARE_ARB_LOCK_EN.
package mux_share_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  // Upper bound for the generic round-robin helper below.
  localparam int RR_MAX_N     = 32;
  localparam int RR_MAX_IDX_W = 5;

  typedef struct packed {
    logic                    found;
    logic [RR_MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Reference round-robin search: first set bit of req[n-1:0] at or after
  // ptr, wrapping from n-1 back to 0.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        j = (ptr + k) % n;
        if (!r.found && req[j]) begin
          r.found = 1'b1;
          r.idx   = j[RR_MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Requester/downstream bundle for mux_share_arbiter.
// req_last exists only when MUX_SHARE_ARB_LOCK_EN is defined.
interface mux_share_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_data;
  logic [N-1:0]          req_ready;
`ifdef MUX_SHARE_ARB_LOCK_EN
  logic [N-1:0]          req_last;
`endif
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic                  out_ready;
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;

  // Requesters plus downstream consumer.
  modport master (
`ifdef MUX_SHARE_ARB_LOCK_EN
    output req_last,
`endif
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_vld, grant_idx
  );

  // The arbiter itself.
  modport slave (
`ifdef MUX_SHARE_ARB_LOCK_EN
    input  req_last,
`endif
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_vld, grant_idx
  );

endinterface

// File: rtl/mux_share_arbiter_rr_picker.sv
// Round-robin picker: rotate req so ptr lands at bit 0, take the lowest set
// bit, then rotate the offset back into an absolute requester index.
module rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  localparam logic [IDX_W:0] NW = (IDX_W+1)'(N);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate: rot[k] is requester (ptr+k) mod N.
  always_comb begin
    int j;
    rot = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      rot[k] = req_i[j];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) off = k[IDX_W-1:0];
    end
  end

  // Unrotate: add ptr back, modulo N (N need not be a power of two).
  always_comb begin
    sum   = {1'b0, ptr_i} + {1'b0, off};
    idx_o = (sum >= NW) ? IDX_W'(sum - NW) : sum[IDX_W-1:0];
  end

  assign found_o = |req_i;

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter driving a registered-select shared output mux.
// Defining MUX_SHARE_ARB_LOCK_EN holds the grant across a burst until req_last.
module mux_share_arbiter
  import mux_share_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst_n,
  mux_share_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             granted;
  logic             hs;
  logic             last_beat;
  logic [N-1:0]     rdy;

  rr_picker #(.N(N)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign granted = (state_q == GRANT);
  assign hs      = bus.out_valid & bus.out_ready;

`ifdef MUX_SHARE_ARB_LOCK_EN
  assign last_beat = bus.req_last[gidx_q];
`else
  assign last_beat = 1'b1;
`endif

  // Output mux: select comes only from the registered grant index.
  assign bus.out_valid = granted & bus.req_valid[gidx_q];
  assign bus.out_data  = granted ? bus.req_data[gidx_q] : '0;
  assign bus.grant_vld = granted;
  assign bus.grant_idx = gidx_q;
  assign bus.req_ready = rdy;

  // Ready goes back only to the granted requester.
  always_comb begin
    rdy = '0;
    if (granted) rdy[gidx_q] = bus.out_ready;
  end

  // Next state: arbitrate in IDLE, release on final handshake or valid drop.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gidx_d  = pick_idx;
        end
      end
      GRANT: begin
        if (hs) begin
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
          end
        end else if (!bus.req_valid[gidx_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and grant index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter with an expected-transfer scoreboard.
// Lock-burst stimulus is included when MUX_SHARE_ARB_LOCK_EN is defined.
module tb_mux_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  exp_t exp_q[$];

  mux_share_arbiter_if #(.N(N), .W(W)) bus ();

  mux_share_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic [W-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake pops and checks the next expected transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_hs", {30'b0, bus.grant_idx}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hs_idx",   {30'b0, bus.grant_idx}, {30'b0, e.idx});
          chk("hs_data",  {24'b0, bus.out_data},  {24'b0, e.data});
          chk("hs_ready", {28'b0, bus.req_ready}, 32'd1 << e.idx);
        end
      end
      if (!bus.grant_vld)
        chk("idle_quiet", {23'b0, bus.out_valid, bus.out_data}, 32'd0);
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'hA0 + 8'(i);
`ifdef MUX_SHARE_ARB_LOCK_EN
    bus.req_last  = 4'b1111;
`endif

    // 1. reset with everything requesting
    tick(); tick();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_req_ready", {28'b0, bus.req_ready}, 32'd0);
    chk("rst_grant_vld", {31'b0, bus.grant_vld}, 32'd0);
    chk("rst_out_data",  {24'b0, bus.out_data},  32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("first_grant_vld", {31'b0, bus.grant_vld}, 32'd1);
    chk("first_grant_idx", {30'b0, bus.grant_idx}, 32'd0);

    // 2. all requesting, downstream always ready: 0,1,2,3,0 every 2 cycles
    push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3); push(0, 8'hA0);
    bus.out_ready = 1'b1;
    repeat (9) tick();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("rr_hs_count", hs_cnt, 32'd5);
    chk("rr_q_empty",  exp_q.size(), 32'd0);

    // 3. only requester 3 with rr_ptr=1, then wrap to 0
    bus.req_valid = 4'b1000;
    tick();
    chk("wrap_grant3", {30'b0, bus.grant_idx}, 32'd3);
    push(3, 8'hA3);
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    tick();
    chk("wrap_ptr0", {30'b0, bus.grant_idx}, 32'd0);
    bus.req_valid = 4'b0000;
    tick();

    // 4. grant 2 stalled by downstream, others requesting meanwhile
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      chk("stall_idx",   {30'b0, bus.grant_idx}, 32'd2);
      chk("stall_data",  {24'b0, bus.out_data},  32'hA2);
      chk("stall_ready", {28'b0, bus.req_ready}, 32'd0);
      tick();
    end
    push(2, 8'hA2);
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("stall_single_hs", hs_cnt, 32'd7);
    chk("stall_released",  {31'b0, bus.grant_vld}, 32'd0);

    // 5. grant 1, valid drop, rr_ptr stays at 3
    bus.req_valid = 4'b0010;
    tick();
    chk("drop_grant1", {30'b0, bus.grant_idx}, 32'd1);
    bus.req_valid = 4'b0000;
    tick();
    chk("drop_released", {31'b0, bus.grant_vld}, 32'd0);
    bus.req_valid = 4'b0110;
    tick();
    chk("drop_regrant1", {30'b0, bus.grant_idx}, 32'd1);
    push(1, 8'hA1);
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    chk("drop_hs_count", hs_cnt, 32'd8);

`ifdef MUX_SHARE_ARB_LOCK_EN
    // 6. locked 3-beat burst on 2 while 0 and 3 request
    bus.req_valid = 4'b1101;
    bus.req_last  = 4'b0000;
    tick();
    chk("lock_grant2", {30'b0, bus.grant_idx}, 32'd2);
    push(2, 8'h21); push(2, 8'h22); push(2, 8'h23);
    bus.req_data[2] = 8'h21;
    bus.out_ready   = 1'b1;
    tick();
    chk("lock_held_vld", {31'b0, bus.grant_vld}, 32'd1);
    chk("lock_held_idx", {30'b0, bus.grant_idx}, 32'd2);
    bus.req_data[2] = 8'h22;
    tick();
    bus.req_data[2] = 8'h23;
    bus.req_last    = 4'b0100;
    tick();
    bus.out_ready = 1'b0;
    tick();
    chk("lock_next3", {30'b0, bus.grant_idx}, 32'd3);
    chk("lock_hs_count", hs_cnt, 32'd11);
    bus.req_valid   = 4'b0000;
    bus.req_data[2] = 8'hA2;
    tick();
`endif

    tick();
    chk("final_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
